mem_stage_mc: RTL and testbench

Parametrised memory stage with a multi-cycle data-memory access sequencer, byte/halfword/word loads and stores with sign or zero extension, misalignment trapping, and an integrated MEM/WB pipeline register. Sits between the EX/MEM register and WB. It resolves branches combinationally toward IF and raises a stall toward the hazard unit while a memory access of configurable latency is outstanding.

---
 rtl/mem_stage_mc_pkg.sv | 32 +++
 rtl/mem_stage_mc_if.sv | 63 ++++++
 rtl/mem_stage_mc_data_memory_be.sv | 36 +++
 rtl/mem_stage_mc.sv | 158 +++++++++++++++
 tb/tb_mem_stage_mc.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_mc_pkg.sv
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared encodings and the byte-lane mask helper for the memory stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Little-endian lane enables; the reserved size code behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << addr;
      SIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_mc_if.sv
// ============================================================================
// Module : mem_stage_mc_if
// Brief  : EX/MEM-side inputs, branch feedback and MEM/WB outputs of the stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_stage_mc_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5
);

  logic               i_MEM_valid;
  logic               i_MEM_reg_write;
  logic               i_MEM_mem_to_reg;
  logic               i_MEM_mem_read;
  logic               i_MEM_mem_write;
  logic [1:0]         i_MEM_size;
  logic               i_MEM_unsigned;
  logic               i_MEM_branch;
  logic               i_MEM_branch_ne;
  logic               i_MEM_zero;
  logic [NB_PC-1:0]   i_MEM_branch_addr;
  logic [NB_ADDR-1:0] i_MEM_alu_result;
  logic [NB_DATA-1:0] i_MEM_write_data;
  logic [NB_REG-1:0]  i_MEM_selected_reg;

  logic               o_MEM_stall;
  logic               o_MEM_branch_taken;
  logic [NB_PC-1:0]   o_MEM_branch_addr;
  logic               o_WB_valid;
  logic               o_WB_reg_write;
  logic               o_WB_mem_to_reg;
  logic               o_WB_misaligned;
  logic [NB_DATA-1:0] o_WB_mem_data;
  logic [NB_ADDR-1:0] o_WB_alu_result;
  logic [NB_REG-1:0]  o_WB_selected_reg;

  modport master (
    output i_MEM_valid, i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_mem_read,
           i_MEM_mem_write, i_MEM_size, i_MEM_unsigned, i_MEM_branch,
           i_MEM_branch_ne, i_MEM_zero, i_MEM_branch_addr, i_MEM_alu_result,
           i_MEM_write_data, i_MEM_selected_reg,
    input  o_MEM_stall, o_MEM_branch_taken, o_MEM_branch_addr, o_WB_valid,
           o_WB_reg_write, o_WB_mem_to_reg, o_WB_misaligned, o_WB_mem_data,
           o_WB_alu_result, o_WB_selected_reg
  );

  modport slave (
    input  i_MEM_valid, i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_mem_read,
           i_MEM_mem_write, i_MEM_size, i_MEM_unsigned, i_MEM_branch,
           i_MEM_branch_ne, i_MEM_zero, i_MEM_branch_addr, i_MEM_alu_result,
           i_MEM_write_data, i_MEM_selected_reg,
    output o_MEM_stall, o_MEM_branch_taken, o_MEM_branch_addr, o_WB_valid,
           o_WB_reg_write, o_WB_mem_to_reg, o_WB_misaligned, o_WB_mem_data,
           o_WB_alu_result, o_WB_selected_reg
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_mc_data_memory_be.sv
// ============================================================================
// Module : data_memory_be
// Brief  : Word-organised data RAM, byte-masked synchronous write, async read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_be #(
  parameter int MEM_DEPTH = 256,
  parameter int NB_IDX    = $clog2(MEM_DEPTH)
) (
  input  wire logic              i_clock,
  input  wire logic              i_we,
  input  wire logic [3:0]        i_be,
  input  wire logic [NB_IDX-1:0] i_addr,
  input  wire logic [31:0]       i_wdata,
  output logic      [31:0]       o_rdata
);

  logic [31:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_stage_mc.sv
// ============================================================================
// Module : mem_stage_mc
// Brief  : Multi-cycle memory stage: access sequencer, load extension, MEM/WB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int NB_ADDR     = 32,
  parameter int NB_DATA     = 32,
  parameter int NB_PC       = 32,
  parameter int NB_REG      = 5,
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 1
) (
  input  wire logic     i_clock,
  input  wire logic     i_reset,
  mem_stage_mc_if.slave bus
);

  localparam int         NB_IDX     = $clog2(MEM_DEPTH);
  localparam logic       c_multi    = (MEM_LATENCY > 1);
  localparam logic [3:0] c_cnt_init = 4'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);
  localparam logic [0:0] c_st_idle  = 1'(ST_IDLE);
  localparam logic [0:0] c_st_wait  = 1'(ST_WAIT);

  logic [0:0]         r_state;
  logic [3:0]         r_cnt;

  logic               w_is_word;
  logic               w_mem_op;
  logic               w_misaligned;
  logic               w_aligned_op;
  logic               w_stall;
  logic               w_commit;
  logic               w_we;
  logic               w_load;
  logic [1:0]         w_lane;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [NB_DATA-1:0] w_load_data;

  assign w_lane    = bus.i_MEM_alu_result[1:0];
  assign w_is_word = (bus.i_MEM_size == SIZE_WORD) || (bus.i_MEM_size == 2'b11);
  assign w_mem_op  = bus.i_MEM_valid && (bus.i_MEM_mem_read || bus.i_MEM_mem_write);

  assign w_misaligned = w_mem_op &&
                        (((bus.i_MEM_size == SIZE_HALF) && w_lane[0]) ||
                         (w_is_word && (w_lane != 2'b00)));
  assign w_aligned_op = w_mem_op && !w_misaligned;

  // While waiting the inputs are held, so only the countdown decides the stall.
  always_comb begin
    w_stall = 1'b0;
    if (r_state == c_st_idle) begin
      w_stall = w_aligned_op && c_multi;
    end else begin
      w_stall = (r_cnt != 4'd0);
    end
  end

  assign w_commit = w_aligned_op && !w_stall;
  assign w_we     = w_commit && bus.i_MEM_mem_write && !i_reset;
  assign w_load   = w_commit && bus.i_MEM_mem_read && !bus.i_MEM_mem_write;

  assign w_be = lane_mask(bus.i_MEM_size, w_lane);

  always_comb begin
    w_wdata = bus.i_MEM_write_data[31:0];
    case (bus.i_MEM_size)
      SIZE_BYTE: w_wdata = {4{bus.i_MEM_write_data[7:0]}};
      SIZE_HALF: w_wdata = {2{bus.i_MEM_write_data[15:0]}};
      default:   w_wdata = bus.i_MEM_write_data[31:0];
    endcase
  end

  data_memory_be #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_dmem (
    .i_clock (i_clock),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (bus.i_MEM_alu_result[2 +: NB_IDX]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_byte = w_rdata[8*w_lane +: 8];
  assign w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_load_data = w_rdata;
    case (bus.i_MEM_size)
      SIZE_BYTE: w_load_data = bus.i_MEM_unsigned ? {24'd0, w_byte}
                                                  : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: w_load_data = bus.i_MEM_unsigned ? {16'd0, w_half}
                                                  : {{16{w_half[15]}}, w_half};
      default:   w_load_data = w_rdata;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= c_st_idle;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_aligned_op && c_multi) begin
            r_state <= c_st_wait;
            r_cnt   <= c_cnt_init;
          end
        end
        default: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= c_st_idle;
          end
        end
      endcase
    end
  end

  // Stalled cycles and bubbles both push an all-zero bubble into WB.
  always_ff @(posedge i_clock) begin
    if (i_reset || !bus.i_MEM_valid || w_stall) begin
      bus.o_WB_valid        <= 1'b0;
      bus.o_WB_reg_write    <= 1'b0;
      bus.o_WB_mem_to_reg   <= 1'b0;
      bus.o_WB_misaligned   <= 1'b0;
      bus.o_WB_mem_data     <= '0;
      bus.o_WB_alu_result   <= '0;
      bus.o_WB_selected_reg <= '0;
    end else begin
      bus.o_WB_valid        <= 1'b1;
      bus.o_WB_reg_write    <= bus.i_MEM_reg_write && !w_misaligned;
      bus.o_WB_mem_to_reg   <= bus.i_MEM_mem_to_reg;
      bus.o_WB_misaligned   <= w_misaligned;
      bus.o_WB_mem_data     <= w_load ? w_load_data : '0;
      bus.o_WB_alu_result   <= bus.i_MEM_alu_result;
      bus.o_WB_selected_reg <= bus.i_MEM_selected_reg;
    end
  end

  assign bus.o_MEM_stall        = w_stall;
  assign bus.o_MEM_branch_taken = bus.i_MEM_valid && bus.i_MEM_branch &&
                                  (bus.i_MEM_zero ^ bus.i_MEM_branch_ne);
  assign bus.o_MEM_branch_addr  = bus.i_MEM_branch_addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_mc.sv
// ============================================================================
// Module : tb_mem_stage_mc
// Brief  : Directed bench; three stage instances with latencies 1, 4 and 3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int          t_sel = 0;
  logic        t_valid = 1'b0;
  logic        t_reg_write = 1'b0;
  logic        t_mem_to_reg = 1'b0;
  logic        t_rd = 1'b0;
  logic        t_wr = 1'b0;
  logic [1:0]  t_size = 2'b10;
  logic        t_uns = 1'b0;
  logic        t_branch = 1'b0;
  logic        t_bne = 1'b0;
  logic        t_zero = 1'b0;
  logic [31:0] t_baddr = '0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_data = '0;
  logic [4:0]  t_reg = '0;

  logic        ob_stall [3];
  logic        ob_taken [3];
  logic [31:0] ob_baddr [3];
  logic        ob_valid [3];
  logic        ob_rw    [3];
  logic        ob_mis   [3];
  logic [31:0] ob_data  [3];
  logic [31:0] ob_alu   [3];
  logic [4:0]  ob_reg   [3];

  mem_stage_mc_if bus [3] ();

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 4 : 3);
    assign bus[k].i_MEM_valid        = t_valid && (t_sel == k);
    assign bus[k].i_MEM_reg_write    = t_reg_write;
    assign bus[k].i_MEM_mem_to_reg   = t_mem_to_reg;
    assign bus[k].i_MEM_mem_read     = t_rd;
    assign bus[k].i_MEM_mem_write    = t_wr;
    assign bus[k].i_MEM_size         = t_size;
    assign bus[k].i_MEM_unsigned     = t_uns;
    assign bus[k].i_MEM_branch       = t_branch;
    assign bus[k].i_MEM_branch_ne    = t_bne;
    assign bus[k].i_MEM_zero         = t_zero;
    assign bus[k].i_MEM_branch_addr  = t_baddr;
    assign bus[k].i_MEM_alu_result   = t_addr;
    assign bus[k].i_MEM_write_data   = t_data;
    assign bus[k].i_MEM_selected_reg = t_reg;

    mem_stage_mc #(.MEM_LATENCY(LAT)) u_dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus[k])
    );

    assign ob_stall[k] = bus[k].o_MEM_stall;
    assign ob_taken[k] = bus[k].o_MEM_branch_taken;
    assign ob_baddr[k] = bus[k].o_MEM_branch_addr;
    assign ob_valid[k] = bus[k].o_WB_valid;
    assign ob_rw[k]    = bus[k].o_WB_reg_write;
    assign ob_mis[k]   = bus[k].o_WB_misaligned;
    assign ob_data[k]  = bus[k].o_WB_mem_data;
    assign ob_alu[k]   = bus[k].o_WB_alu_result;
    assign ob_reg[k]   = bus[k].o_WB_selected_reg;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one instruction to instance sel, holds it through the stall and
  // returns just after the WB-loading edge with the stage idle again.
  task automatic do_op(input int sel, input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data,
                       output int stalls);
    t_sel = sel; t_valid = 1'b1; t_rd = rd; t_wr = wr; t_size = size; t_uns = uns;
    t_addr = addr; t_data = data; t_reg = 5'd7;
    t_reg_write = rd | ~wr; t_mem_to_reg = rd;
    stalls = 0;
    @(negedge clk);
    while (ob_stall[sel] && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 20) check_eq("stall_timeout", 32'(stalls), 32'd0);
    @(posedge clk); #1;
    t_valid = 1'b0; t_rd = 1'b0; t_wr = 1'b0;
  endtask

  int st;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_wb_valid", 32'(ob_valid[0]), 32'd0);
    check_eq("rst_wb_data", ob_data[1], 32'd0);
    check_eq("rst_stall", 32'(ob_stall[1]), 32'd0);

    // Latency 1: sign / zero extended byte loads.
    do_op(0, 0, 1, 2'b10, 0, 32'h10, 32'h8000_00F0, st);
    check_eq("l1_sw_stalls", 32'(st), 32'd0);
    do_op(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, st);
    check_eq("l1_lb", ob_data[0], 32'hFFFF_FFF0);
    check_eq("l1_lb_valid", 32'(ob_valid[0]), 32'd1);
    do_op(0, 1, 0, 2'b00, 1, 32'h13, 32'h0, st);
    check_eq("l1_lbu", ob_data[0], 32'h0000_0080);

    // Non-memory instruction.
    do_op(0, 0, 0, 2'b10, 0, 32'h55AA, 32'h0, st);
    check_eq("alu_result", ob_alu[0], 32'h55AA);
    check_eq("alu_memdata", ob_data[0], 32'h0);
    check_eq("alu_reg", 32'(ob_reg[0]), 32'd7);

    // Latency 4: halfword store into an existing word.
    do_op(1, 0, 1, 2'b10, 0, 32'h20, 32'h1122_3344, st);
    check_eq("l4_sw_stalls", 32'(st), 32'd3);
    do_op(1, 0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF, st);
    check_eq("l4_sh_stalls", 32'(st), 32'd3);
    do_op(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, st);
    check_eq("l4_lw", ob_data[1], 32'hBEEF_3344);
    do_op(1, 1, 0, 2'b01, 0, 32'h22, 32'h0, st);
    check_eq("l4_lh", ob_data[1], 32'hFFFF_BEEF);

    // Misalignment: no wait, trap flag, no write.
    do_op(1, 1, 0, 2'b10, 0, 32'h06, 32'h0, st);
    check_eq("mis_stalls", 32'(st), 32'd0);
    check_eq("mis_flag", 32'(ob_mis[1]), 32'd1);
    check_eq("mis_regwrite", 32'(ob_rw[1]), 32'd0);
    check_eq("mis_valid", 32'(ob_valid[1]), 32'd1);
    do_op(0, 0, 1, 2'b10, 0, 32'h04, 32'hA5A5_A5A5, st);
    do_op(0, 0, 1, 2'b10, 0, 32'h06, 32'h0000_0000, st);
    do_op(0, 1, 0, 2'b10, 0, 32'h04, 32'h0, st);
    check_eq("mis_nowrite", ob_data[0], 32'hA5A5_A5A5);

    // Branch resolution.
    t_sel = 0; t_valid = 1'b1; t_branch = 1'b1; t_bne = 1'b1; t_zero = 1'b0;
    t_baddr = 32'h1000_0040; t_reg_write = 1'b0;
    #1 check_eq("bne_taken", 32'(ob_taken[0]), 32'd1);
    check_eq("bne_addr", ob_baddr[0], 32'h1000_0040);
    t_zero = 1'b1;
    #1 check_eq("bne_zero", 32'(ob_taken[0]), 32'd0);
    t_zero = 1'b0; t_valid = 1'b0;
    #1 check_eq("bne_bubble", 32'(ob_taken[0]), 32'd0);
    t_branch = 1'b0; t_bne = 1'b0;
    @(posedge clk); #1;

    // Address wrap modulo 4*MEM_DEPTH bytes.
    do_op(0, 0, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, st);
    do_op(0, 1, 0, 2'b10, 0, 32'h000, 32'h0, st);
    check_eq("wrap_lw", ob_data[0], 32'hCAFE_F00D);

    // Latency 3: reset while waiting discards the store.
    do_op(2, 0, 1, 2'b10, 0, 32'h40, 32'h1234_5678, st);
    check_eq("l3_sw_stalls", 32'(st), 32'd2);
    t_sel = 2; t_valid = 1'b1; t_wr = 1'b1; t_size = 2'b10; t_addr = 32'h40;
    t_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_eq("l3_wait_stall", 32'(ob_stall[2]), 32'd1);
    rst = 1'b1; t_valid = 1'b0; t_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("l3_rst_stall", 32'(ob_stall[2]), 32'd0);
    check_eq("l3_rst_valid", 32'(ob_valid[2]), 32'd0);
    check_eq("l3_rst_data", ob_data[2], 32'd0);
    do_op(2, 1, 0, 2'b10, 0, 32'h40, 32'h0, st);
    check_eq("l3_old_value", ob_data[2], 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
